// File: rtl/ram_dma_ci_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : ram_dma_ci_ctrl
// Brief    : CI-port scratch RAM (true dual-port) with a burst DMA master.
//            Define DMA_IRQ_EN to add the irq output.
// Revision : 1.0
// ============================================================================
module ram_dma_ci_ctrl #(
    parameter logic [7:0] CUSTOM_ID  = 8'h0B,
    parameter int         RAM_ADDR_W = 9,
    parameter int         MAX_BURST  = 16
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    input  logic [7:0]  ciN,
    input  logic [31:0] valueA,
    input  logic [31:0] valueB,
    output logic        done,
    output logic [31:0] result,
    output logic        bus_req,
    input  logic        bus_grant,
    output logic        bus_begin,
    output logic        bus_rnw,
    output logic [31:0] bus_addr,
    output logic [7:0]  bus_len,
    input  logic [31:0] bus_rdata,
    input  logic        bus_rvalid,
    output logic [31:0] bus_wdata,
    output logic        bus_wvalid,
    input  logic        bus_busy,
    input  logic        bus_end,
    input  logic        bus_err
`ifdef DMA_IRQ_EN
    ,
    output logic        irq
`endif
);

    localparam int DEPTH = 2 ** RAM_ADDR_W;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_REQ     = 3'd1,
        S_GRANTED = 3'd2,
        S_BEGIN   = 3'd3,
        S_XFER    = 3'd4,
        S_DONE    = 3'd5
    } state_t;

    state_t                  state_q, state_d;

    logic [31:0]             bus_base_q;
    logic [RAM_ADDR_W-1:0]   ram_base_q;
    logic [9:0]              size_q;
    logic [8:0]              burst_q;
    logic                    busy_q;
    logic                    err_q;
    logic                    dir_rnw_q;
    logic [31:0]             cur_addr_q;
    logic [RAM_ADDR_W-1:0]   ptr_q;
    logic [9:0]              rem_q;
    logic [9:0]              blen_q;
    logic [9:0]              wbeats_q;
    logic                    done_q;
    logic [31:0]             result_q;
    logic                    rd_pend_q;
    logic [31:0]             ram_rd_q;
    logic [31:0]             wdata_q;
    logic [31:0]             mem_q [DEPTH];
`ifdef DMA_IRQ_EN
    logic                    irq_q;
`endif

    logic                    w_accept;
    logic                    w_legal;
    logic [2:0]              w_sel;
    logic                    w_we;
    logic [RAM_ADDR_W-1:0]   w_cpu_addr;
    logic                    w_cpu_wr;
    logic                    w_cpu_rd;
    logic                    w_reg_wr;
    logic                    w_dma_go;
    logic                    w_stat_clr;
    logic [9:0]              w_blen;
    logic                    w_dma_wr;
    logic                    w_wvalid;
    logic                    w_beat_acc;
    logic                    w_fetch;
    logic                    w_err;
    logic [31:0]             w_rd_data;

    // ------------------------------------------------------------------
    // CI decode
    // ------------------------------------------------------------------
    assign w_accept   = start && (ciN == CUSTOM_ID);
    assign w_legal    = (valueA[31:13] == 19'd0);
    assign w_sel      = valueA[12:10];
    assign w_we       = valueA[9];
    assign w_cpu_addr = valueA[RAM_ADDR_W-1:0];
    assign w_cpu_wr   = w_accept && w_legal && (w_sel == 3'd0) && w_we;
    assign w_cpu_rd   = w_accept && w_legal && (w_sel == 3'd0) && !w_we;
    assign w_reg_wr   = w_accept && w_legal && w_we && !busy_q &&
                        (w_sel >= 3'd1) && (w_sel <= 3'd5);
    assign w_stat_clr = w_reg_wr && (w_sel == 3'd5) && valueB[2];
    // Exactly one direction bit and a non-empty block launch a transfer.
    assign w_dma_go   = w_reg_wr && (w_sel == 3'd5) && (valueB[0] ^ valueB[1]) &&
                        (size_q != 10'd0);

    // ------------------------------------------------------------------
    // DMA datapath helpers
    // ------------------------------------------------------------------
    assign w_blen     = (rem_q < {1'b0, burst_q}) ? rem_q : {1'b0, burst_q};
    assign w_dma_wr   = (state_q == S_XFER) && dir_rnw_q && bus_rvalid;
    assign w_beat_acc = w_wvalid && !bus_busy;
    // Prefetch keeps one word ahead so the next beat is ready right after acceptance.
    assign w_fetch    = ((state_q == S_BEGIN) && !dir_rnw_q) ||
                        (w_beat_acc && (wbeats_q > 10'd1));
    assign w_err      = (state_q != S_IDLE) && bus_err;

    always_comb begin
        w_rd_data = '0;
        if (w_legal && !w_we) begin
            case (w_sel)
                3'd1:    w_rd_data = bus_base_q;
                3'd2:    w_rd_data = 32'(ram_base_q);
                3'd3:    w_rd_data = {22'd0, size_q};
                3'd4:    w_rd_data = {23'd0, burst_q};
                3'd5:    w_rd_data = {30'd0, err_q, busy_q};
                default: w_rd_data = '0;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        bus_req   = 1'b0;
        bus_begin = 1'b0;
        bus_addr  = '0;
        bus_len   = '0;
        w_wvalid  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (w_dma_go) state_d = S_REQ;
            end
            S_REQ: begin
                bus_req = 1'b1;
                if (bus_grant) state_d = S_GRANTED;
            end
            S_GRANTED: begin
                bus_req = 1'b1;
                state_d = S_BEGIN;
            end
            S_BEGIN: begin
                bus_req   = 1'b1;
                bus_begin = 1'b1;
                bus_addr  = cur_addr_q;
                bus_len   = 8'(w_blen - 10'd1);
                state_d   = S_XFER;
            end
            S_XFER: begin
                bus_req  = 1'b1;
                w_wvalid = !dir_rnw_q && (wbeats_q != 10'd0);
                if (bus_end) state_d = (rem_q != 10'd0) ? S_BEGIN : S_DONE;
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        if (w_err) state_d = S_IDLE;
    end

    assign bus_rnw    = (state_q != S_IDLE) && dir_rnw_q;
    assign bus_wvalid = w_wvalid;
    assign bus_wdata  = w_wvalid ? wdata_q : 32'd0;

    // ------------------------------------------------------------------
    // Registers, CI response and DMA counters
    // ------------------------------------------------------------------
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            bus_base_q <= '0;
            ram_base_q <= '0;
            size_q     <= '0;
            burst_q    <= '0;
            busy_q     <= 1'b0;
            err_q      <= 1'b0;
            dir_rnw_q  <= 1'b0;
            cur_addr_q <= '0;
            ptr_q      <= '0;
            rem_q      <= '0;
            blen_q     <= '0;
            wbeats_q   <= '0;
            done_q     <= 1'b0;
            result_q   <= '0;
            rd_pend_q  <= 1'b0;
`ifdef DMA_IRQ_EN
            irq_q      <= 1'b0;
`endif
        end else begin
            done_q    <= 1'b0;
            result_q  <= '0;
            rd_pend_q <= w_cpu_rd;
            if (rd_pend_q) begin
                done_q   <= 1'b1;
                result_q <= ram_rd_q;
            end else if (w_accept && !w_cpu_rd) begin
                done_q   <= 1'b1;
                result_q <= w_rd_data;
            end

            if (w_reg_wr) begin
                case (w_sel)
                    3'd1: bus_base_q <= valueB;
                    3'd2: ram_base_q <= valueB[RAM_ADDR_W-1:0];
                    3'd3: size_q     <= valueB[9:0];
                    3'd4: begin
                        if (valueB == 32'd0)
                            burst_q <= 9'd1;
                        else if (valueB > 32'(MAX_BURST))
                            burst_q <= 9'(MAX_BURST);
                        else
                            burst_q <= valueB[8:0];
                    end
                    default: ;
                endcase
            end
            if (w_stat_clr) begin
                err_q <= 1'b0;
`ifdef DMA_IRQ_EN
                irq_q <= 1'b0;
`endif
            end
            if (w_dma_go) begin
                busy_q     <= 1'b1;
                dir_rnw_q  <= valueB[0];
                cur_addr_q <= bus_base_q;
                ptr_q      <= ram_base_q;
                rem_q      <= size_q;
            end

            case (state_q)
                S_BEGIN: begin
                    blen_q   <= w_blen;
                    wbeats_q <= w_blen;
                    rem_q    <= rem_q - w_blen;
                    if (!dir_rnw_q) ptr_q <= ptr_q + 1'b1;
                end
                S_XFER: begin
                    if (w_dma_wr) ptr_q <= ptr_q + 1'b1;
                    if (w_beat_acc) begin
                        wbeats_q <= wbeats_q - 10'd1;
                        if (wbeats_q > 10'd1) ptr_q <= ptr_q + 1'b1;
                    end
                    if (bus_end) cur_addr_q <= cur_addr_q + {20'd0, blen_q, 2'b00};
                end
                S_DONE: begin
                    busy_q <= 1'b0;
`ifdef DMA_IRQ_EN
                    irq_q  <= 1'b1;
`endif
                end
                default: ;
            endcase

            if (w_err) begin
                busy_q <= 1'b0;
                err_q  <= 1'b1;
`ifdef DMA_IRQ_EN
                irq_q  <= 1'b1;
`endif
            end
        end
    end

    // ------------------------------------------------------------------
    // RAM: CPU port is written last so it wins a same-address collision;
    // reads return pre-write contents.
    // ------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (w_dma_wr) mem_q[ptr_q] <= bus_rdata;
        if (w_cpu_wr) mem_q[w_cpu_addr] <= valueB;
        if (w_cpu_rd) ram_rd_q <= mem_q[w_cpu_addr];
        if (w_fetch)  wdata_q  <= mem_q[ptr_q];
    end

    assign done   = done_q;
    assign result = result_q;
`ifdef DMA_IRQ_EN
    assign irq    = irq_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_ram_dma_ci_ctrl.sv
`default_nettype none
// Scoreboard bench for ram_dma_ci_ctrl: CI responses queued at issue time and
// checked by a monitor; a behavioural bus slave and array models judge the DMA.
module tb_ram_dma_ci_ctrl;

    localparam int DEPTH = 512;
    localparam int MAXB  = 16;
    localparam int BMW   = 4096;

    logic        clock, reset, start;
    logic [7:0]  ciN;
    logic [31:0] valueA, valueB;
    logic        done;
    logic [31:0] result;
    logic        bus_req, bus_grant, bus_begin, bus_rnw;
    logic [31:0] bus_addr;
    logic [7:0]  bus_len;
    logic [31:0] bus_rdata;
    logic        bus_rvalid;
    logic [31:0] bus_wdata;
    logic        bus_wvalid, bus_busy, bus_end, bus_err;
`ifdef DMA_IRQ_EN
    logic        irq;
`endif

    ram_dma_ci_ctrl dut (
        .clock(clock), .reset(reset), .start(start), .ciN(ciN),
        .valueA(valueA), .valueB(valueB), .done(done), .result(result),
        .bus_req(bus_req), .bus_grant(bus_grant), .bus_begin(bus_begin),
        .bus_rnw(bus_rnw), .bus_addr(bus_addr), .bus_len(bus_len),
        .bus_rdata(bus_rdata), .bus_rvalid(bus_rvalid), .bus_wdata(bus_wdata),
        .bus_wvalid(bus_wvalid), .bus_busy(bus_busy), .bus_end(bus_end),
        .bus_err(bus_err)
`ifdef DMA_IRQ_EN
        , .irq(irq)
`endif
    );

    int tests = 0;
    int fails = 0;
    int cyc   = 0;

    logic [31:0] ref_ram [DEPTH];
    logic [31:0] bmem    [BMW];
    logic [31:0] exp_res_q[$];
    int          exp_cyc_q[$];
    logic [31:0] act_addr_q[$];
    logic [7:0]  act_len_q[$];
    logic [31:0] exp_addr_q[$];
    logic [7:0]  exp_len_q[$];

    int          sl_gdelay = 1;
    int          sl_bmode = 0;
    int          sl_err_beat = -1;

    initial clock = 1'b0;
    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s got %h expected %h", nm, act, exp);
        end
    endtask

    // Monitor: every done pulse must match the oldest queued expectation.
    always @(negedge clock) begin
        if (reset === 1'b1 && done === 1'b1) begin
            if (exp_res_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL ci_unexpected_done got result %h expected no done", result);
            end else begin
                check("ci_result", result, exp_res_q.pop_front());
                check("ci_latency_cycle", 32'(cyc), 32'(exp_cyc_q.pop_front()));
            end
        end
    end

    // Behavioural bus slave, driven on the falling edge.
    initial begin : slave
        int gcnt = 0, left = 0, word = 0, beat = 0;
        bit active = 0, rnw = 0, chk_req = 0, hold_chk = 0;
        logic [31:0] held = 0;
        bus_grant = 0; bus_rvalid = 0; bus_rdata = 0; bus_busy = 0; bus_end = 0; bus_err = 0;
        forever begin
            @(negedge clock);
            if (!reset) begin
                bus_grant = 0; bus_rvalid = 0; bus_busy = 0; bus_end = 0; bus_err = 0;
                active = 0; gcnt = 0; chk_req = 0; hold_chk = 0;
            end else begin
                if (chk_req) begin
                    check("err_bus_req_drop", 32'(bus_req), 32'd0);
                    chk_req = 0;
                end
                if (hold_chk) begin
                    check("wvalid_held", 32'(bus_wvalid), 32'd1);
                    check("wdata_held", bus_wdata, held);
                    hold_chk = 0;
                end
                bus_rvalid = 0; bus_end = 0; bus_err = 0;
                if (!bus_req) begin
                    bus_grant = 0;
                    gcnt = 0;
                end else if (!bus_grant) begin
                    if (gcnt >= sl_gdelay) bus_grant = 1;
                    else gcnt++;
                end
                if (bus_begin) begin
                    act_addr_q.push_back(bus_addr);
                    act_len_q.push_back(bus_len);
                    active = 1; left = int'(bus_len) + 1; word = int'(bus_addr >> 2); rnw = bus_rnw;
                end else if (active && rnw) begin
                    if (left == 0) begin
                        bus_end = 1; active = 0;
                    end else if ($urandom_range(3) != 0) begin
                        if (beat == sl_err_beat) begin
                            bus_err = 1; active = 0; chk_req = 1;
                        end else begin
                            bus_rvalid = 1; bus_rdata = bmem[word % BMW];
                            word++; left--; beat++;
                        end
                    end
                end else if (active && !rnw) begin
                    if (left == 0) begin
                        bus_end = 1; active = 0; bus_busy = 0;
                    end else begin
                        bus_busy = (sl_bmode != 0) ? !bus_busy : ($urandom_range(2) == 0);
                        if (bus_wvalid) begin
                            if (!bus_busy) begin
                                bmem[word % BMW] = bus_wdata;
                                word++; left--;
                            end else begin
                                hold_chk = 1; held = bus_wdata;
                            end
                        end
                    end
                end
                if (!active) beat = (bus_req) ? beat : 0;
            end
        end
    end

    task automatic ci_raw(input logic [7:0] op, input logic [31:0] a, input logic [31:0] b,
                          input bit expect_done, input logic [31:0] exp, input int lat);
        @(posedge clock); #1;
        start = 1; ciN = op; valueA = a; valueB = b;
        if (expect_done) begin
            exp_res_q.push_back(exp);
            exp_cyc_q.push_back(cyc + lat);
        end
        @(posedge clock); #1;
        start = 0; ciN = 0; valueA = 0; valueB = 0;
        repeat (lat) @(posedge clock);
    endtask

    task automatic ram_wr(input int addr, input logic [31:0] d);
        logic [8:0] a9 = 9'(addr);
        ci_raw(8'h0B, {19'd0, 3'd0, 1'b1, a9}, d, 1, 32'd0, 1);
        ref_ram[addr % DEPTH] = d;
    endtask

    task automatic ram_rd(input int addr);
        logic [8:0] a9 = 9'(addr);
        ci_raw(8'h0B, {19'd0, 3'd0, 1'b0, a9}, 32'd0, 1, ref_ram[addr % DEPTH], 2);
    endtask

    task automatic reg_wr(input logic [2:0] sel, input logic [31:0] d);
        ci_raw(8'h0B, {19'd0, sel, 1'b1, 9'd0}, d, 1, 32'd0, 1);
    endtask

    task automatic reg_rd(input logic [2:0] sel, input logic [31:0] exp);
        ci_raw(8'h0B, {19'd0, sel, 1'b0, 9'd0}, 32'd0, 1, exp, 1);
    endtask

    task automatic wait_idle();
        int k = 0;
        while (bus_req === 1'b1 && k < 3000) begin
            @(negedge clock);
            k++;
        end
        check("dma_completes_in_budget", 32'(k < 3000), 32'd1);
        repeat (3) @(posedge clock);
    endtask

    task automatic dma(input bit rnw, input logic [31:0] ba, input int rp, input int n,
                       input int bw, input int gd, input int bm);
        int be, rem;
        logic [31:0] a;
        reg_wr(3'd1, ba);
        reg_wr(3'd2, 32'(rp));
        reg_wr(3'd3, 32'(n));
        reg_wr(3'd4, 32'(bw));
        be = (bw == 0) ? 1 : ((bw > MAXB) ? MAXB : bw);
        act_addr_q.delete(); act_len_q.delete(); exp_addr_q.delete(); exp_len_q.delete();
        rem = n; a = ba;
        while (rem > 0) begin
            int l = (rem < be) ? rem : be;
            exp_addr_q.push_back(a);
            exp_len_q.push_back(8'(l - 1));
            a = a + 32'(4 * l);
            rem = rem - l;
        end
        if (rnw)
            for (int i = 0; i < n; i++)
                ref_ram[(rp + i) % DEPTH] = bmem[((ba >> 2) + 32'(i)) % BMW];
        sl_gdelay = gd; sl_bmode = bm; sl_err_beat = -1;
        reg_wr(3'd5, rnw ? 32'd1 : 32'd2);
        wait_idle();
        check("burst_count", 32'(act_addr_q.size()), 32'(exp_addr_q.size()));
        for (int i = 0; i < exp_addr_q.size() && i < act_addr_q.size(); i++) begin
            check("burst_addr", act_addr_q[i], exp_addr_q[i]);
            check("burst_len", 32'(act_len_q[i]), 32'(exp_len_q[i]));
        end
        reg_rd(3'd5, 32'd0);
        if (!rnw)
            for (int i = 0; i < n; i++)
                check("ram_to_bus_data", bmem[((ba >> 2) + 32'(i)) % BMW], ref_ram[(rp + i) % DEPTH]);
    endtask

    initial begin : main
        int k;
        reset = 0; start = 0; ciN = 0; valueA = 0; valueB = 0;
        for (int i = 0; i < BMW; i++) bmem[i] = $urandom;
        repeat (3) @(posedge clock);
        #1;
        check("rst_done", 32'(done), 32'd0);
        check("rst_result", result, 32'd0);
        check("rst_bus_req", 32'(bus_req), 32'd0);
        check("rst_bus_begin", 32'(bus_begin), 32'd0);
        check("rst_bus_rnw", 32'(bus_rnw), 32'd0);
        check("rst_bus_addr", bus_addr, 32'd0);
        check("rst_bus_len", 32'(bus_len), 32'd0);
        check("rst_bus_wvalid", 32'(bus_wvalid), 32'd0);
        check("rst_bus_wdata", bus_wdata, 32'd0);
        reset = 1;
        reg_rd(3'd5, 32'd0);
        reg_rd(3'd1, 32'd0);

        for (int i = 0; i < DEPTH; i++) ram_wr(i, $urandom);

        ram_wr(1, 32'h11);
        ram_rd(1);
        ci_raw(8'h0B, 32'h1000_0201, 32'd1, 1, 32'd0, 1);
        ram_rd(1);
        ci_raw(8'h0C, 32'h0000_0201, 32'h55, 0, 32'd0, 1);
        ram_rd(1);
        reg_rd(3'd6, 32'd0);
        reg_wr(3'd7, 32'hFFFF_FFFF);

        reg_wr(3'd1, 32'hABCD_1234); reg_rd(3'd1, 32'hABCD_1234);
        reg_wr(3'd2, 32'h155);       reg_rd(3'd2, 32'h155);
        reg_wr(3'd3, 32'h7FF);       reg_rd(3'd3, 32'h3FF);
        reg_wr(3'd4, 32'd0);         reg_rd(3'd4, 32'd1);
        reg_wr(3'd4, 32'd100);       reg_rd(3'd4, 32'd16);
        reg_wr(3'd4, 32'd8);         reg_rd(3'd4, 32'd8);

        for (int i = 0; i < 60; i++) begin
            k = $urandom_range(DEPTH - 1);
            if ($urandom_range(1) == 1) ram_wr(k, $urandom);
            else ram_rd(k);
        end

        dma(1, 32'h1000, 'h10, 20, 8, 2, 0);
        for (int i = 'h10; i <= 'h23; i++) ram_rd(i);

        dma(0, 32'h2000, 'h40, 4, 16, 1, 1);

        // Error on the second beat, with write attempts while busy.
        reg_wr(3'd1, 32'h1800); reg_wr(3'd2, 32'h80); reg_wr(3'd3, 32'd6); reg_wr(3'd4, 32'd4);
        act_addr_q.delete(); act_len_q.delete();
        sl_gdelay = 40; sl_bmode = 0; sl_err_beat = 1;
        reg_wr(3'd5, 32'd1);
        reg_wr(3'd1, 32'hDEAD_0000);
        reg_rd(3'd1, 32'h1800);
        reg_rd(3'd5, 32'd1);
        reg_wr(3'd5, 32'd4);
        reg_rd(3'd5, 32'd1);
        ref_ram['h80] = bmem['h600];
        wait_idle();
        sl_err_beat = -1;
        reg_rd(3'd5, 32'd2);
        ram_rd('h80);
        ram_rd('h81);
`ifdef DMA_IRQ_EN
        check("irq_on_err", 32'(irq), 32'd1);
`endif
        reg_wr(3'd5, 32'd4);
        reg_rd(3'd5, 32'd0);

        dma(1, 32'h3000, 'h1FE, 4, 16, 0, 0);
        ram_rd('h1FE); ram_rd('h1FF); ram_rd(0); ram_rd(1);
`ifdef DMA_IRQ_EN
        check("irq_after_done", 32'(irq), 32'd1);
        reg_wr(3'd5, 32'd4);
        check("irq_cleared", 32'(irq), 32'd0);
`endif

        reg_wr(3'd3, 32'd0); reg_wr(3'd5, 32'd1);
        check("size0_no_req", 32'(bus_req), 32'd0);
        reg_rd(3'd5, 32'd0);
        reg_wr(3'd3, 32'd5); reg_wr(3'd5, 32'd3);
        check("both_dirs_no_req", 32'(bus_req), 32'd0);
        reg_rd(3'd5, 32'd0);

        for (int t = 0; t < 6; t++) begin
            int n  = $urandom_range(40, 1);
            int rp = $urandom_range(DEPTH - 1);
            bit rd = ($urandom_range(1) == 1);
            dma(rd, 32'h2400 + 32'(t * 'h200), rp, n, $urandom_range(20), $urandom_range(5), 0);
            if (rd) for (int i = 0; i < n; i++) ram_rd((rp + i) % DEPTH);
        end

        // Reset in the middle of a bus->RAM transfer.
        reg_wr(3'd1, 32'h1000); reg_wr(3'd2, 32'h100); reg_wr(3'd3, 32'd16); reg_wr(3'd4, 32'd16);
        sl_gdelay = 0;
        reg_wr(3'd5, 32'd1);
        k = 0;
        while (bus_rvalid !== 1'b1 && k < 500) begin
            @(negedge clock);
            k++;
        end
        check("xfer_reached_before_reset", 32'(k < 500), 32'd1);
        @(posedge clock); #1;
        reset = 0;
        #1;
        check("async_rst_bus_req", 32'(bus_req), 32'd0);
        check("async_rst_bus_rnw", 32'(bus_rnw), 32'd0);
        check("async_rst_bus_begin", 32'(bus_begin), 32'd0);
        check("async_rst_bus_wvalid", 32'(bus_wvalid), 32'd0);
        check("async_rst_done", 32'(done), 32'd0);
        repeat (2) @(posedge clock);
        #2;
        reset = 1;
        reg_rd(3'd1, 32'd0);
        reg_rd(3'd3, 32'd0);
        reg_rd(3'd5, 32'd0);

        repeat (5) @(posedge clock);
        check("scoreboard_drained", 32'(exp_res_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
